// File: rtl/asg_seq_pkg.sv
// Shared types and constants for the arbitrary-signal-generator segment sequencer.
package asg_seq_pkg;

    localparam int RSZ_DEF  = 14;
    localparam int NSEG_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_PLAY
    } state_e;

    localparam logic [1:0] FLD_OFS   = 2'd0;
    localparam logic [1:0] FLD_SIZE  = 2'd1;
    localparam logic [1:0] FLD_STEP  = 2'd2;
    localparam logic [1:0] FLD_DWELL = 2'd3;

    // A zero dwell still plays the segment for one cycle.
    function automatic logic [31:0] dwell_min1(input logic [31:0] dwell);
        return (dwell == 32'd0) ? 32'd1 : dwell;
    endfunction

endpackage

// File: rtl/asg_seq_tbl.sv
// Segment table: NSEG entries of {ofs, size, step, dwell}, one write port and
// one registered read port.
module asg_seq_tbl
    import asg_seq_pkg::*;
#(
    parameter int RSZ  = RSZ_DEF,
    parameter int NSEG = NSEG_DEF,
    localparam int AW  = $clog2(NSEG),
    localparam int PW  = RSZ + 16
) (
    input  logic          dac_clk_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    fld,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [PW-1:0] rd_ofs,
    output logic [PW-1:0] rd_size,
    output logic [PW-1:0] rd_step,
    output logic [31:0]   rd_dwell
);

    logic [PW-1:0] ofs_mem   [NSEG];
    logic [PW-1:0] size_mem  [NSEG];
    logic [PW-1:0] step_mem  [NSEG];
    logic [31:0]   dwell_mem [NSEG];

    // NOTE: storage arrays carry no reset; a reset loop over every entry would
    // turn the array into flops with wide reset fan-out for no functional gain.
    always_ff @(posedge dac_clk_i) begin
        if (we) begin
            case (fld)
                FLD_OFS:   ofs_mem[waddr]   <= PW'(wdata);
                FLD_SIZE:  size_mem[waddr]  <= PW'(wdata);
                FLD_STEP:  step_mem[waddr]  <= PW'(wdata);
                default:   dwell_mem[waddr] <= wdata;
            endcase
        end
    end

    always_ff @(posedge dac_clk_i) begin
        rd_ofs   <= ofs_mem[raddr];
        rd_size  <= size_mem[raddr];
        rd_step  <= step_mem[raddr];
        rd_dwell <= dwell_mem[raddr];
    end

endmodule

// File: rtl/asg_seq.sv
// Segment sequencer: steps a generator channel through a table of segments.
// Optional pass counting is compiled in with ASG_SEQ_LOOP_CNT_EN.
module asg_seq
    import asg_seq_pkg::*;
#(
    parameter int RSZ  = RSZ_DEF,
    parameter int NSEG = NSEG_DEF,
    localparam int AW  = $clog2(NSEG),
    localparam int PW  = RSZ + 16
) (
    input  logic          dac_clk_i,
    input  logic          dac_rstn_i,
    input  logic          tbl_we_i,
    input  logic [AW-1:0] tbl_addr_i,
    input  logic [1:0]    tbl_fld_i,
    input  logic [31:0]   tbl_wdata_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          loop_i,
`ifdef ASG_SEQ_LOOP_CNT_EN
    input  logic [15:0]   loop_cnt_i,
`endif
    input  logic [AW:0]   nseg_i,
    output logic [PW-1:0] set_ofs_o,
    output logic [PW-1:0] set_size_o,
    output logic [PW-1:0] set_step_o,
    output logic          set_rst_o,
    output logic          trig_sw_o,
    output logic [AW-1:0] seg_idx_o,
    output logic          busy_o,
    output logic          done_o
);

    state_e        state_q, state_d;
    logic [AW-1:0] seg_q, seg_d;
    logic [31:0]   dwell_sh_q, dwell_cnt_q;
    logic [PW-1:0] ofs_q, size_q, step_q;
    logic          rst_q, trig_q, done_q;
    logic          rst_set, trig_set, done_set, start_acc, wrap;
    logic          seg_end, last_seg, loop_ok;
    logic [PW-1:0] rd_ofs, rd_size, rd_step;
    logic [31:0]   rd_dwell;

    // Read address follows the next index so the entry is ready during LOAD.
    asg_seq_tbl #(.RSZ(RSZ), .NSEG(NSEG)) u_tbl (
        .dac_clk_i (dac_clk_i),
        .we        (tbl_we_i),
        .waddr     (tbl_addr_i),
        .fld       (tbl_fld_i),
        .wdata     (tbl_wdata_i),
        .raddr     (seg_d),
        .rd_ofs    (rd_ofs),
        .rd_size   (rd_size),
        .rd_step   (rd_step),
        .rd_dwell  (rd_dwell)
    );

    assign seg_end  = (state_q == ST_PLAY) && (dwell_cnt_q == 32'd1);
    assign last_seg = ({1'b0, seg_q} + (AW+1)'(1)) >= nseg_i;

`ifdef ASG_SEQ_LOOP_CNT_EN
    logic [15:0] loop_cnt_q, pass_cnt_q;

    assign loop_ok = loop_i && ((loop_cnt_q == 16'd0) ||
                     (({1'b0, pass_cnt_q} + 17'd1) < {1'b0, loop_cnt_q}));

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            loop_cnt_q <= '0;
            pass_cnt_q <= '0;
        end else if (start_acc) begin
            loop_cnt_q <= loop_cnt_i;
            pass_cnt_q <= '0;
        end else if (wrap) begin
            pass_cnt_q <= pass_cnt_q + 16'd1;
        end
    end
`else
    assign loop_ok = loop_i;
`endif

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state_q     <= ST_IDLE;
            seg_q       <= '0;
            dwell_sh_q  <= '0;
            dwell_cnt_q <= '0;
            ofs_q       <= '0;
            size_q      <= '0;
            step_q      <= '0;
            rst_q       <= 1'b1;
            trig_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            rst_q   <= rst_set;
            trig_q  <= trig_set;
            done_q  <= done_set;
            if (state_q == ST_LOAD && state_d == ST_ARM) begin
                ofs_q      <= rd_ofs;
                size_q     <= rd_size;
                step_q     <= rd_step;
                dwell_sh_q <= rd_dwell;
            end
            if (trig_set)
                dwell_cnt_q <= dwell_min1(dwell_sh_q);
            else if (state_q == ST_PLAY && !seg_end)
                dwell_cnt_q <= dwell_cnt_q - 32'd1;
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        rst_set   = 1'b0;
        trig_set  = 1'b0;
        done_set  = 1'b0;
        start_acc = 1'b0;
        wrap      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    if (nseg_i != '0) begin
                        state_d   = ST_LOAD;
                        seg_d     = '0;
                        start_acc = 1'b1;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            ST_LOAD: state_d = ST_ARM;
            ST_ARM: begin
                state_d  = ST_PLAY;
                trig_set = 1'b1;
            end
            default: begin
                if (seg_end) begin
                    if (!last_seg) begin
                        state_d = ST_LOAD;
                        seg_d   = seg_q + AW'(1);
                    end else if (loop_ok) begin
                        state_d = ST_LOAD;
                        seg_d   = '0;
                        wrap    = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        done_set = 1'b1;
                        rst_set  = 1'b1;
                    end
                end
            end
        endcase
        // Stop overrides everything else while a sequence is running.
        if (stop_i && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            seg_d    = seg_q;
            rst_set  = 1'b1;
            trig_set = 1'b0;
            done_set = 1'b0;
            wrap     = 1'b0;
        end
    end

    always_comb begin
        busy_o     = (state_q != ST_IDLE);
        set_rst_o  = rst_q || (state_q == ST_ARM);
        trig_sw_o  = trig_q;
        done_o     = done_q;
        seg_idx_o  = seg_q;
        set_ofs_o  = ofs_q;
        set_size_o = size_q;
        set_step_o = step_q;
    end

endmodule

// File: tb/tb_asg_seq.sv
// Self-checking bench for asg_seq: expected per-cycle outputs are built from a
// segment-level plan (LOAD, ARM, dwell PLAY cycles, final IDLE) kept in a queue.
module tb_asg_seq;
    import asg_seq_pkg::*;

    localparam int RSZ  = RSZ_DEF;
    localparam int NSEG = NSEG_DEF;
    localparam int AW   = $clog2(NSEG);
    localparam int PW   = RSZ + 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tbl_we;
    logic [AW-1:0] tbl_addr;
    logic [1:0]    tbl_fld;
    logic [31:0]   tbl_wdata;
    logic          start, stop, loop;
    logic [15:0]   loop_cnt;
    logic [AW:0]   nseg;
    logic [PW-1:0] set_ofs, set_size, set_step;
    logic          set_rst, trig_sw, busy, done;
    logic [AW-1:0] seg_idx;

    always #5 clk = ~clk;

    asg_seq #(.RSZ(RSZ), .NSEG(NSEG)) dut (
        .dac_clk_i   (clk),
        .dac_rstn_i  (rst_n),
        .tbl_we_i    (tbl_we),
        .tbl_addr_i  (tbl_addr),
        .tbl_fld_i   (tbl_fld),
        .tbl_wdata_i (tbl_wdata),
        .start_i     (start),
        .stop_i      (stop),
        .loop_i      (loop),
`ifdef ASG_SEQ_LOOP_CNT_EN
        .loop_cnt_i  (loop_cnt),
`endif
        .nseg_i      (nseg),
        .set_ofs_o   (set_ofs),
        .set_size_o  (set_size),
        .set_step_o  (set_step),
        .set_rst_o   (set_rst),
        .trig_sw_o   (trig_sw),
        .seg_idx_o   (seg_idx),
        .busy_o      (busy),
        .done_o      (done)
    );

    typedef struct packed {
        logic          busy;
        logic [AW-1:0] seg;
        logic          srst;
        logic          trig;
        logic          done;
        logic [PW-1:0] ofs;
        logic [PW-1:0] size;
        logic [PW-1:0] step;
    } obs_t;

    obs_t          expq[$];
    logic [PW-1:0] m_ofs[NSEG], m_size[NSEG], m_step[NSEG];
    logic [31:0]   m_dwell[NSEG];
    logic [PW-1:0] c_ofs, c_size, c_step;
    int            c_seg;
    int            n_checks = 0;
    int            n_errs = 0;

    function automatic obs_t observe();
        return obs_t'{busy, seg_idx, set_rst, trig_sw, done, set_ofs, set_size, set_step};
    endfunction

    function automatic obs_t model_out(input logic b, input logic sr, input logic tr, input logic dn);
        return obs_t'{b, AW'(c_seg), sr, tr, dn, c_ofs, c_size, c_step};
    endfunction

    task automatic check(input string tag, input obs_t obs, input obs_t expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errs++;
            $error("FAIL %s observed=%h required=%h", tag, obs, expv);
        end
    endtask

    // One segment: LOAD shows the old config, ARM onward shows the new one.
    task automatic push_seg(input int idx, input int cap);
        int d;
        c_seg = idx;
        expq.push_back(model_out(1'b1, 1'b0, 1'b0, 1'b0));
        c_ofs  = m_ofs[idx];
        c_size = m_size[idx];
        c_step = m_step[idx];
        expq.push_back(model_out(1'b1, 1'b1, 1'b0, 1'b0));
        d = (m_dwell[idx] == 32'd0) ? 1 : int'(m_dwell[idx]);
        if (cap > 0 && cap < d) d = cap;
        for (int k = 0; k < d; k++)
            expq.push_back(model_out(1'b1, 1'b0, k == 0, 1'b0));
    endtask

    task automatic push_done();
        expq.push_back(model_out(1'b0, 1'b1, 1'b0, 1'b1));
    endtask

    task automatic write_fld(input int idx, input logic [1:0] fld, input logic [31:0] data);
        tbl_we = 1'b1; tbl_addr = AW'(idx); tbl_fld = fld; tbl_wdata = data;
        @(posedge clk); #1;
        tbl_we = 1'b0;
        case (fld)
            FLD_OFS:  m_ofs[idx]  = PW'(data);
            FLD_SIZE: m_size[idx] = PW'(data);
            FLD_STEP: m_step[idx] = PW'(data);
            default:  m_dwell[idx] = data;
        endcase
    endtask

    task automatic write_entry(input int idx, input logic [31:0] dw);
        write_fld(idx, FLD_OFS, $urandom);
        write_fld(idx, FLD_SIZE, $urandom);
        write_fld(idx, FLD_STEP, $urandom);
        write_fld(idx, FLD_DWELL, dw);
    endtask

    // Walks the expected queue one clock at a time; optionally writes the table mid-run.
    task automatic run_queue(input string name, input int wr_at, input int wr_idx,
                             input logic [1:0] wr_fld, input logic [31:0] wr_data);
        for (int i = 0; i < expq.size(); i++) begin
            @(posedge clk); #1;
            start = 1'b0; stop = 1'b0; tbl_we = 1'b0;
            check($sformatf("%s[%0d]", name, i), observe(), expq[i]);
            if (i == wr_at) begin
                tbl_we = 1'b1; tbl_addr = AW'(wr_idx); tbl_fld = wr_fld; tbl_wdata = wr_data;
            end
        end
        expq.delete();
    endtask

    task automatic check_quiet(input string name);
        @(posedge clk); #1;
        tbl_we = 1'b0;
        check(name, observe(), model_out(1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic stop_now(input string name);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0; start = 1'b0;
        check(name, observe(), model_out(1'b0, 1'b1, 1'b0, 1'b0));
        check_quiet({name, "_after"});
    endtask

    initial begin
        rst_n = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_fld = '0; tbl_wdata = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0; loop_cnt = 16'd0; nseg = '0;
        c_ofs = '0; c_size = '0; c_step = '0; c_seg = 0;

        #12;
        check("reset_hold", observe(), model_out(1'b0, 1'b1, 1'b0, 1'b0));
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_release", observe(), model_out(1'b0, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < NSEG; i++) write_entry(i, $urandom_range(0, 6));

        // Two segments, dwell 3 and 5, no loop.
        write_entry(0, 32'd3);
        write_entry(1, 32'd5);
        nseg = 2; loop = 1'b0;
        push_seg(0, 0); push_seg(1, 0); push_done();
        start = 1'b1;
        run_queue("two_seg", -1, 0, FLD_OFS, 0);
        check_quiet("two_seg_idle");

        // Zero dwell plays one cycle.
        write_fld(0, FLD_DWELL, 32'd0);
        nseg = 1;
        push_seg(0, 0); push_done();
        start = 1'b1;
        run_queue("dwell0", -1, 0, FLD_OFS, 0);
        check_quiet("dwell0_idle");

        // Random tables and segment counts.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, NSEG);
            for (int i = 0; i < n; i++) write_entry(i, $urandom_range(0, 4));
            nseg = (AW+1)'(n);
            for (int i = 0; i < n; i++) push_seg(i, 0);
            push_done();
            start = 1'b1;
            run_queue($sformatf("rand%0d", r), -1, 0, FLD_OFS, 0);
            check_quiet($sformatf("rand%0d_idle", r));
        end

        // Looping over three segments, then stop mid-PLAY.
        write_entry(0, 32'd2); write_entry(1, 32'd1); write_entry(2, 32'd4);
        nseg = 3; loop = 1'b1;
        for (int s = 0; s < 6; s++) push_seg(s % 3, 0);
        push_seg(0, 1);
        start = 1'b1;
        run_queue("loop3", -1, 0, FLD_OFS, 0);
        stop_now("loop3_stop");

        // Start and stop together while busy.
        write_fld(0, FLD_DWELL, 32'd4);
        nseg = 2; loop = 1'b0;
        push_seg(0, 2);
        start = 1'b1;
        run_queue("ss_pre", -1, 0, FLD_OFS, 0);
        start = 1'b1;
        stop_now("start_stop");

        // Start with no segments.
        nseg = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("nseg0_done", observe(), model_out(1'b0, 1'b0, 1'b0, 1'b1));
        check_quiet("nseg0_idle");

        // Rewriting the playing entry only shows at its next LOAD.
        write_entry(0, 32'd5); write_entry(1, 32'd2);
        nseg = 2; loop = 1'b1;
        push_seg(0, 0); push_seg(1, 0);
        m_ofs[0] = PW'(32'h1234_0000);
        push_seg(0, 2);
        start = 1'b1;
        run_queue("rewrite", 3, 0, FLD_OFS, 32'h1234_0000);
        stop_now("rewrite_stop");

`ifdef ASG_SEQ_LOOP_CNT_EN
        // Two full passes, then a normal finish.
        loop_cnt = 16'd2; nseg = 2; loop = 1'b1;
        push_seg(0, 0); push_seg(1, 0); push_seg(0, 0); push_seg(1, 0); push_done();
        start = 1'b1;
        run_queue("loopcnt2", -1, 0, FLD_OFS, 0);
        check_quiet("loopcnt2_idle");
        loop_cnt = 16'd0;
`endif

        // Asynchronous reset in the middle of PLAY.
        write_fld(0, FLD_DWELL, 32'd5);
        nseg = 1; loop = 1'b0;
        push_seg(0, 2);
        start = 1'b1;
        run_queue("prerst", -1, 0, FLD_OFS, 0);
        rst_n = 1'b0;
        #1;
        c_ofs = '0; c_size = '0; c_step = '0; c_seg = 0;
        check("reset_mid_play", observe(), model_out(1'b0, 1'b1, 1'b0, 1'b0));
        #2 rst_n = 1'b1;
        check_quiet("reset_mid_release");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/asg_seq.md
ASG_SEQ -- requirements
Module: asg_seq

Interface
REQ-001 SHALL have parameter RSZ, default 14, meaning buffer address width; pointer fields are RSZ+16 bits.
REQ-002 SHALL have parameter NSEG, default 8, meaning segment table depth; a power of 2, at least 2.
REQ-003 SHALL have port dac_clk_i, input, width 1, the single clock.
REQ-004 SHALL have port dac_rstn_i, input, width 1; reset is asynchronous and active-low.
REQ-005 SHALL have tbl_we_i, tbl_addr_i, tbl_fld_i and tbl_wdata_i, all inputs, widths 1, log2(NSEG), 2 and 32: table write strobe, entry, field (0=ofs, 1=size, 2=step, 3=dwell) and data.
REQ-006 SHALL have start_i, stop_i and loop_i, all inputs of width 1: start pulse, stop pulse and loop-enable level.
REQ-007 SHALL have nseg_i, input, width log2(NSEG)+1: number of active segments.
REQ-008 SHALL have set_ofs_o, set_size_o and set_step_o, all outputs of width RSZ+16: channel configuration.
REQ-009 SHALL have set_rst_o and trig_sw_o, outputs of width 1: channel reset pulse and software trigger pulse.
REQ-010 SHALL have seg_idx_o (output, width log2(NSEG)), busy_o (output, width 1) and done_o (output, width 1, pulse).

Function
REQ-011 SHALL implement states IDLE, LOAD, ARM, PLAY.
REQ-012 SHALL go IDLE->LOAD on start_i when nseg_i!=0; start_i with nseg_i==0 SHALL pulse done_o and stay in IDLE.
REQ-013 SHALL spend one cycle in LOAD and register table[seg_idx] into the set_*_o outputs and the dwell shadow.
REQ-014 SHALL spend one cycle in ARM with set_rst_o=1 and the set_*_o outputs already stable.
REQ-015 SHALL, on entry to PLAY, pulse trig_sw_o for exactly 1 cycle and load the dwell counter with dwell; a dwell of 0 SHALL be treated as 1.
REQ-016 SHALL decrement the dwell counter each PLAY cycle and end the segment when the count is 1, giving exactly max(dwell,1) PLAY cycles.
REQ-017 SHALL, at segment end with seg_idx<nseg_i-1, increment seg_idx and go to LOAD.
REQ-018 SHALL, at the last segment, go to LOAD with seg_idx=0 if looping is permitted (REQ-029); otherwise it SHALL go to IDLE, pulse done_o and assert set_rst_o for 1 cycle.
REQ-019 SHALL, on stop_i in any non-IDLE state, go to IDLE next cycle with set_rst_o=1 for 1 cycle and no done_o; stop_i SHALL win over a simultaneous start_i or segment end.
REQ-020 SHALL ignore start_i while busy.
REQ-021 SHALL accept table writes in every state; a write to the entry currently playing SHALL not affect the outputs until that entry's next LOAD.
REQ-022 SHALL sample nseg_i and loop_i only at the start_i acceptance and at each segment end.
REQ-023 SHALL drive busy_o=1 in every state except IDLE; seg_idx_o SHALL equal the segment index currently loaded.
REQ-024 SHALL truncate the ofs, size and step fields to RSZ+16 bits on write; dwell SHALL be the full 32 bits.

Reset
REQ-025 SHALL, while dac_rstn_i=0, asynchronously force: state IDLE, seg_idx 0, dwell counter 0, set_*_o 0, set_rst_o 1, trig_sw_o 0, busy_o 0, done_o 0.
REQ-026 SHALL NOT reset table contents; their contents after power-up are undefined.
REQ-027 SHALL drive set_rst_o=0 from the first clock edge after reset release.

Configuration
REQ-028 SHALL compile loop-count support in with macro ASG_SEQ_LOOP_CNT_EN.
REQ-029 SHALL, with ASG_SEQ_LOOP_CNT_EN defined, add input loop_cnt_i (16 bits) latched at start; 0 means infinite, N means N full passes then stop as in REQ-018 (loop_i still required).
REQ-030 SHALL, without ASG_SEQ_LOOP_CNT_EN, loop indefinitely while loop_i=1.

Structure
REQ-031 SHALL place the state enum, field codes (FLD_OFS, FLD_SIZE, FLD_STEP, FLD_DWELL) and the default RSZ/NSEG in package asg_seq_pkg.
REQ-032 SHALL implement the table as sub-module asg_seq_tbl: NSEG x 4-field register file, one write port and one registered read port.

Verification
REQ-033 SHALL pass: nseg=2, dwell {3,5}, loop=0, start -> set_rst at ARM, trig_sw pulses 3 and 5 PLAY cycles apart plus the LOAD and ARM cycles, then done_o and set_rst pulses.
REQ-034 SHALL pass: dwell=0 -> exactly 1 PLAY cycle.
REQ-035 SHALL pass: loop=1, nseg=3 -> seg_idx sequence 0,1,2,0,1...; then stop_i mid-PLAY -> IDLE next cycle, set_rst pulse, no done_o.
REQ-036 SHALL pass: start and stop in the same cycle while busy -> IDLE; start with nseg=0 -> done_o pulse and stays in IDLE.
REQ-037 SHALL pass: rewrite the ofs of the playing entry to 0x1234_0000 -> outputs unchanged until that entry's next LOAD.
REQ-038 SHALL pass: with ASG_SEQ_LOOP_CNT_EN and loop_cnt_i=2, nseg=2 -> 4 segments played, then done_o; assert dac_rstn_i mid-PLAY -> all outputs at reset values immediately.
